// File: rtl/ds1302_access_sched.sv
// ============================================================================
// Module      : ds1302_access_sched
// Description : Serialises host/poll read and write requests into per-register
//               DS1302 command transactions and keeps the last good BCD snapshot.
//               Optional macro DS1302_WP_CTRL_EN wraps writes with WP clear/set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ds1302_access_sched #(
  parameter int POLL_CYCLES    = 100_000_000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic [7:0] wr_years,
  input  logic [7:0] wr_months,
  input  logic [7:0] wr_dates,
  input  logic [7:0] wr_hours,
  input  logic [7:0] wr_minutes,
  input  logic [7:0] wr_seconds,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_wdata,
  input  logic       rsp_done,
  input  logic [7:0] rsp_rdata,
  output logic [7:0] years,
  output logic [7:0] months,
  output logic [7:0] dates,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       time_valid,
  output logic       busy,
  output logic       rd_done,
  output logic       wr_done,
  output logic       err
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_ISSUE = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_DONE  = 3'd3;
  localparam logic [2:0] c_ST_ABORT = 3'd4;

  localparam logic [2:0] c_RD_LAST = 3'd5;
`ifdef DS1302_WP_CTRL_EN
  localparam logic [2:0] c_WR_LAST = 3'd7;
`else
  localparam logic [2:0] c_WR_LAST = 3'd5;
`endif

  localparam int              c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic              r_is_wr;
  logic [2:0]        r_step;
  logic              r_rd_pend;
  logic              r_wr_pend;
  logic [c_TO_W-1:0] r_to_cnt;
  logic [7:0]        r_wr_sh  [6];
  logic [7:0]        r_wr_act [6];
  logic [7:0]        r_stage  [6];
  logic              w_poll_hit;
  logic              w_last_step;
  logic              w_start;
  logic [2:0]        w_wr_idx;

  assign w_last_step = r_is_wr ? (r_step == c_WR_LAST) : (r_step == c_RD_LAST);
  assign w_start     = (r_state == c_ST_IDLE) && (r_rd_pend || r_wr_pend);

`ifdef DS1302_WP_CTRL_EN
  assign w_wr_idx = r_step - 3'd1;
`else
  assign w_wr_idx = r_step;
`endif

  // Free-running poll timer; keeps counting while a sequence is in flight.
  generate
    if (POLL_CYCLES > 0) begin : g_poll
      localparam int                c_POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
      localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(POLL_CYCLES - 1);
      logic [c_POLL_W-1:0] r_poll_cnt;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_poll_cnt <= '0;
        end else if (r_poll_cnt == c_POLL_LAST) begin
          r_poll_cnt <= '0;
        end else begin
          r_poll_cnt <= r_poll_cnt + 1'b1;
        end
      end

      assign w_poll_hit = (r_poll_cnt == c_POLL_LAST);
    end else begin : g_no_poll
      assign w_poll_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (r_rd_pend || r_wr_pend) w_next_state = c_ST_ISSUE;
      c_ST_ISSUE: if (cmd_ready) w_next_state = c_ST_WAIT;
      c_ST_WAIT: begin
        if (rsp_done) begin
          w_next_state = w_last_step ? c_ST_DONE : c_ST_ISSUE;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_next_state = c_ST_ABORT;
        end
      end
      c_ST_DONE:  w_next_state = c_ST_IDLE;
      c_ST_ABORT: w_next_state = c_ST_IDLE;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (r_state == c_ST_ISSUE);
    busy      = (r_state != c_ST_IDLE);
    rd_done   = (r_state == c_ST_DONE) && !r_is_wr;
    wr_done   = (r_state == c_ST_DONE) && r_is_wr;
    err       = (r_state == c_ST_ABORT);
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    if (r_state == c_ST_ISSUE) begin
      if (!r_is_wr) begin
        case (r_step)
          3'd0:    cmd_addr = 8'h81;
          3'd1:    cmd_addr = 8'h83;
          3'd2:    cmd_addr = 8'h85;
          3'd3:    cmd_addr = 8'h87;
          3'd4:    cmd_addr = 8'h89;
          default: cmd_addr = 8'h8D;
        endcase
`ifdef DS1302_WP_CTRL_EN
      end else if (r_step == 3'd0) begin
        cmd_addr  = 8'h8E;
        cmd_wdata = 8'h00;
      end else if (r_step == c_WR_LAST) begin
        cmd_addr  = 8'h8E;
        cmd_wdata = 8'h80;
`endif
      end else begin
        case (w_wr_idx)
          3'd0: begin
            cmd_addr  = 8'h80;
            cmd_wdata = {1'b0, r_wr_act[0][6:0]};  // CH=0 keeps the oscillator running
          end
          3'd1: begin
            cmd_addr  = 8'h82;
            cmd_wdata = r_wr_act[1];
          end
          3'd2: begin
            cmd_addr  = 8'h84;
            cmd_wdata = r_wr_act[2];
          end
          3'd3: begin
            cmd_addr  = 8'h86;
            cmd_wdata = r_wr_act[3];
          end
          3'd4: begin
            cmd_addr  = 8'h88;
            cmd_wdata = r_wr_act[4];
          end
          default: begin
            cmd_addr  = 8'h8C;
            cmd_wdata = r_wr_act[5];
          end
        endcase
      end
    end
  end

  // Set terms come last so a request arriving as its sequence starts is kept.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rd_pend <= 1'b0;
      r_wr_pend <= 1'b0;
      r_is_wr   <= 1'b0;
      r_step    <= 3'd0;
      r_to_cnt  <= '0;
      for (int i = 0; i < 6; i++) begin
        r_wr_sh[i]  <= 8'h00;
        r_wr_act[i] <= 8'h00;
        r_stage[i]  <= 8'h00;
      end
    end else begin
      if (w_start) begin
        r_is_wr <= r_wr_pend;
        r_step  <= 3'd0;
        if (r_wr_pend) begin
          r_wr_pend <= 1'b0;
          r_wr_act  <= r_wr_sh;
        end else begin
          r_rd_pend <= 1'b0;
        end
      end
      if (rd_req || w_poll_hit) r_rd_pend <= 1'b1;
      if (wr_req) begin
        r_wr_pend  <= 1'b1;
        r_wr_sh[0] <= wr_seconds;
        r_wr_sh[1] <= wr_minutes;
        r_wr_sh[2] <= wr_hours;
        r_wr_sh[3] <= wr_dates;
        r_wr_sh[4] <= wr_months;
        r_wr_sh[5] <= wr_years;
      end

      if (r_state == c_ST_WAIT && rsp_done) begin
        if (!r_is_wr) r_stage[r_step] <= rsp_rdata;
        if (!w_last_step) r_step <= r_step + 3'd1;
      end

      if (r_state == c_ST_ISSUE) begin
        r_to_cnt <= '0;
      end else if (r_state == c_ST_WAIT) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // Snapshot only moves on a complete read, so an abort leaves it untouched.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seconds    <= 8'h00;
      minutes    <= 8'h00;
      hours      <= 8'h00;
      dates      <= 8'h00;
      months     <= 8'h00;
      years      <= 8'h00;
      time_valid <= 1'b0;
    end else if (r_state == c_ST_DONE && !r_is_wr) begin
      seconds    <= {1'b0, r_stage[0][6:0]};
      minutes    <= r_stage[1];
      hours      <= {1'b0, r_stage[2][6:0]};
      dates      <= r_stage[3];
      months     <= r_stage[4];
      years      <= r_stage[5];
      time_valid <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ds1302_access_sched.sv
// ============================================================================
// Module      : tb_ds1302_access_sched
// Description : Scoreboard bench for ds1302_access_sched with a driver model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ds1302_access_sched;

  localparam int c_TO = 64;
`ifdef DS1302_WP_CTRL_EN
  localparam int c_N_WR = 8;
`else
  localparam int c_N_WR = 6;
`endif

  logic clk;
  logic rst_n, rd_req, wr_req, cmd_ready, rsp_done;
  logic [7:0] wr_years, wr_months, wr_dates, wr_hours, wr_minutes, wr_seconds, rsp_rdata;
  logic cmd_valid, time_valid, busy, rd_done, wr_done, err;
  logic [7:0] cmd_addr, cmd_wdata, years, months, dates, hours, minutes, seconds;

  logic rst_n1, rd_req1, wr_req1, cmd_ready1, rsp_done1;
  logic [7:0] wr_zero, rsp_rdata1;
  logic cmd_valid1, time_valid1, busy1, rd_done1, wr_done1, err1;
  logic [7:0] cmd_addr1, cmd_wdata1, years1, months1, dates1, hours1, minutes1, seconds1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_cmd_q[$];
  logic [2:0]  exp_evt_q[$];
  logic [7:0]  rsp_q[$];
  logic [2:0]  r_ev;

  ds1302_access_sched #(.POLL_CYCLES(0), .TIMEOUT_CYCLES(c_TO)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req),
    .wr_years(wr_years), .wr_months(wr_months), .wr_dates(wr_dates),
    .wr_hours(wr_hours), .wr_minutes(wr_minutes), .wr_seconds(wr_seconds),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_done(rsp_done), .rsp_rdata(rsp_rdata),
    .years(years), .months(months), .dates(dates), .hours(hours),
    .minutes(minutes), .seconds(seconds), .time_valid(time_valid),
    .busy(busy), .rd_done(rd_done), .wr_done(wr_done), .err(err)
  );

  ds1302_access_sched #(.POLL_CYCLES(50), .TIMEOUT_CYCLES(c_TO)) dut_poll (
    .sys_clk(clk), .sys_rst_n(rst_n1), .rd_req(rd_req1), .wr_req(wr_req1),
    .wr_years(wr_zero), .wr_months(wr_zero), .wr_dates(wr_zero),
    .wr_hours(wr_zero), .wr_minutes(wr_zero), .wr_seconds(wr_zero),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_addr(cmd_addr1),
    .cmd_wdata(cmd_wdata1), .rsp_done(rsp_done1), .rsp_rdata(rsp_rdata1),
    .years(years1), .months(months1), .dates(dates1), .hours(hours1),
    .minutes(minutes1), .seconds(seconds1), .time_valid(time_valid1),
    .busy(busy1), .rd_done(rd_done1), .wr_done(wr_done1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Completion pulses are compared in order against what the stimulus expected.
  always @(negedge clk) begin
    if (rst_n && (rd_done || wr_done || err)) begin
      if (exp_evt_q.size() == 0) begin
        check("evt_unexpected", {29'd0, rd_done, wr_done, err}, 32'd0);
      end else begin
        r_ev = exp_evt_q.pop_front();
        check("evt_order", {29'd0, rd_done, wr_done, err}, {29'd0, r_ev});
      end
    end
  end

  task automatic push_rd();
    exp_cmd_q.push_back(16'h8100);
    exp_cmd_q.push_back(16'h8300);
    exp_cmd_q.push_back(16'h8500);
    exp_cmd_q.push_back(16'h8700);
    exp_cmd_q.push_back(16'h8900);
    exp_cmd_q.push_back(16'h8D00);
    exp_evt_q.push_back(3'b100);
  endtask

  task automatic push_wr(input logic [7:0] s, m, h, d, mo, y);
    wr_seconds = s; wr_minutes = m; wr_hours = h;
    wr_dates = d; wr_months = mo; wr_years = y;
`ifdef DS1302_WP_CTRL_EN
    exp_cmd_q.push_back(16'h8E00);
`endif
    exp_cmd_q.push_back({8'h80, 1'b0, s[6:0]});
    exp_cmd_q.push_back({8'h82, m});
    exp_cmd_q.push_back({8'h84, h});
    exp_cmd_q.push_back({8'h86, d});
    exp_cmd_q.push_back({8'h88, mo});
    exp_cmd_q.push_back({8'h8C, y});
`ifdef DS1302_WP_CTRL_EN
    exp_cmd_q.push_back(16'h8E80);
`endif
    exp_evt_q.push_back(3'b010);
  endtask

  task automatic push_bytes(input logic [7:0] b0, b1, b2, b3, b4, b5);
    rsp_q.push_back(b0); rsp_q.push_back(b1); rsp_q.push_back(b2);
    rsp_q.push_back(b3); rsp_q.push_back(b4); rsp_q.push_back(b5);
  endtask

  task automatic serve_one(input int stall, input bit drop);
    int n;
    logic [7:0] a0, d0, rd;
    logic [15:0] e;
    n = 0;
    while (!cmd_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_valid_seen", {31'd0, cmd_valid}, 32'd1);
    if (!cmd_valid) return;
    a0 = cmd_addr;
    d0 = cmd_wdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_hold", {15'd0, cmd_valid, cmd_addr, cmd_wdata}, {15'd0, 1'b1, a0, d0});
    end
    if (exp_cmd_q.size() == 0) begin
      check("cmd_unexpected", {16'd0, a0, d0}, 32'd0);
    end else begin
      e = exp_cmd_q.pop_front();
      check("cmd_pair", {16'd0, a0, d0}, {16'd0, e});
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("cmd_after_accept", {31'd0, cmd_valid}, 32'd0);
    if (drop) return;
    repeat (2) begin
      @(negedge clk);
      check("no_cmd_before_rsp", {31'd0, cmd_valid}, 32'd0);
    end
    rd = (a0[0] && rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
    rsp_done  = 1'b1;
    rsp_rdata = rd;
    @(negedge clk);
    rsp_done  = 1'b0;
    rsp_rdata = 8'h00;
  endtask

  task automatic serve_n(input int n);
    for (int i = 0; i < n; i++) serve_one(0, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; cmd_ready = 1'b0; rsp_done = 1'b0;
    rsp_rdata = 8'h00; wr_years = 8'h00; wr_months = 8'h00; wr_dates = 8'h00;
    wr_hours = 8'h00; wr_minutes = 8'h00; wr_seconds = 8'h00;
    rst_n1 = 1'b0; rd_req1 = 1'b0; wr_req1 = 1'b0; cmd_ready1 = 1'b0;
    rsp_done1 = 1'b0; rsp_rdata1 = 8'h00; wr_zero = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_snap_lo", {8'd0, hours, minutes, seconds}, 32'd0);
    check("rst_snap_hi", {8'd0, years, months, dates}, 32'd0);
    check("rst_flags", {20'd0, time_valid, rd_done, wr_done, err, cmd_addr}, 32'd0);
    rst_n = 1'b1;
    rst_n1 = 1'b1;
    @(negedge clk);

    // Single read with CH bit set in the seconds byte.
    push_rd();
    push_bytes(8'h85, 8'h59, 8'h23, 8'h31, 8'h12, 8'h24);
    pulse_rd();
    check("lat_edge_n", {31'd0, cmd_valid}, 32'd0);
    @(negedge clk);
    check("lat_edge_n1", {31'd0, cmd_valid}, 32'd1);
    serve_n(6);
    wait_idle();
    check("rd1_sec", {24'd0, seconds}, 32'h05);
    check("rd1_min_hr", {16'd0, minutes, hours}, 32'h5923);
    check("rd1_date_mon_yr", {8'd0, dates, months, years}, 32'h311224);
    check("rd1_time_valid", {31'd0, time_valid}, 32'd1);

    // Write with seconds bit7 set; it must go out cleared.
    push_wr(8'hD8, 8'h59, 8'h23, 8'h31, 8'h12, 8'h24);
    wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    serve_n(c_N_WR);
    wait_idle();
    check("wr_snap_kept", {24'd0, seconds}, 32'h05);

    // Simultaneous read and write: write first, then read.
    push_wr(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h25);
    push_rd();
    push_bytes(8'h90, 8'h11, 8'h92, 8'h04, 8'h05, 8'h25);
    rd_req = 1'b1;
    wr_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    wr_req = 1'b0;
    serve_n(c_N_WR);
    serve_n(6);
    wait_idle();
    check("rd3_sec_hr", {16'd0, seconds, hours}, 32'h1012);
    check("rd3_min_yr", {16'd0, minutes, years}, 32'h1125);

    // Stalled handshake, plus two requests during the sequence merged into one.
    push_rd();
    push_bytes(8'h33, 8'h44, 8'h15, 8'h28, 8'h02, 8'h26);
    pulse_rd();
    serve_one(10, 1'b0);
    pulse_rd();
    @(negedge clk);
    pulse_rd();
    push_rd();
    push_bytes(8'h33, 8'h44, 8'h15, 8'h28, 8'h02, 8'h26);
    serve_n(5);
    serve_n(6);
    wait_idle();
    repeat (5) @(negedge clk);
    check("merged_no_extra", {31'd0, cmd_valid}, 32'd0);
    check("rd4_snap", {seconds, minutes, hours, dates}, 32'h33441528);

    // No response on the third read step: abort after the timeout.
    exp_cmd_q.push_back(16'h8100);
    exp_cmd_q.push_back(16'h8300);
    exp_cmd_q.push_back(16'h8500);
    exp_evt_q.push_back(3'b001);
    rsp_q.push_back(8'h01);
    rsp_q.push_back(8'h02);
    pulse_rd();
    serve_one(0, 1'b0);
    serve_one(0, 1'b0);
    serve_one(0, 1'b1);
    n = 0;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, c_TO);
    @(negedge clk);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_snap", {seconds, minutes, months, years}, 32'h33440226);
    rsp_done = 1'b1;
    rsp_rdata = 8'hFF;
    @(negedge clk);
    rsp_done = 1'b0;
    rsp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("stray_rsp_ignored", {23'd0, busy, cmd_valid, seconds}, 32'h033);

    // Poll instance: reset during a write, then the first auto-read.
    rst_n1 = 1'b0;
    @(negedge clk);
    rst_n1 = 1'b1;
    wr_req1 = 1'b1;
    @(negedge clk);
    wr_req1 = 1'b0;
    @(negedge clk);
    check("p_wr_issue", {31'd0, cmd_valid1}, 32'd1);
    #1;
    rst_n1 = 1'b0;
    #1;
    check("p_rst_async", {30'd0, cmd_valid1, busy1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n1 = 1'b1;
    n = 0;
    while (!cmd_valid1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("p_poll_window", {31'd0, (n >= 50 && n <= 51)}, 32'd1);
    check("p_poll_addr", {24'd0, cmd_addr1}, 32'h81);

    repeat (3) @(negedge clk);
    check("cmd_q_empty", exp_cmd_q.size(), 32'd0);
    check("evt_q_empty", exp_evt_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
